// File: rtl/dac_ramp_pkg.sv
// -----------------------------------------------------------------------------
// dac_ramp_pkg
// Shared definitions for the DAC ramp generator: waveform mode encodings and
// the direction constants reported on the dir output.
// -----------------------------------------------------------------------------
package dac_ramp_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'd0,
    MODE_SAW_UP   = 2'd1,
    MODE_SAW_DOWN = 2'd2,
    MODE_TRIANGLE = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage : dac_ramp_pkg

// File: rtl/ramp_prescaler.sv
// -----------------------------------------------------------------------------
// ramp_prescaler
// Divides enabled clock cycles down to a step tick: one tick every
// prescale+1 enabled cycles.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset (counter to 0)
//   enable    counts and ticks only while high; low holds the counter
//   clear     synchronous restart of the counter (used by preload)
//   prescale  terminal count; tick when the counter reaches it
//   tick      combinational tick, valid in the cycle the counter hits prescale
// -----------------------------------------------------------------------------
module ramp_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;

  // >= rather than == so that lowering prescale below the running count
  // ticks at once instead of stalling for a full counter roll-over.
  assign tick = enable && (cnt_q >= prescale);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : ramp_prescaler

// File: rtl/dac_ramp_gen.sv
// -----------------------------------------------------------------------------
// dac_ramp_gen
// Programmable R2R DAC code generator: hold, sawtooth up, sawtooth down and
// triangle waveforms with programmable step, inclusive upper limit, tick
// prescaler and synchronous preload. All outputs are registered.
//
// Ports:
//   clk         system clock (10 MHz nominal)
//   rst         synchronous active-high reset, overrides everything
//   enable      prescaler/stepping enable; low freezes prescaler and count
//   mode        0 HOLD, 1 SAW_UP, 2 SAW_DOWN, 3 TRIANGLE
//   step        amount added/subtracted per tick
//   limit       inclusive upper bound of the count
//   prescale    tick every prescale+1 enabled cycles
//   load        synchronous preload strobe (honoured even when disabled)
//   load_value  preload value, clamped to limit
//   count       registered DAC code
//   dir         registered direction, 1 = descending (TRIANGLE only)
//   wrap        registered one-cycle pulse on wrap or turn-around
// -----------------------------------------------------------------------------
module dac_ramp_gen
  import dac_ramp_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      step,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  output logic [WIDTH-1:0]      count,
  output logic                  dir,
  output logic                  wrap
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  mode_e            mode_s;

  // Widened operands: the sum carries into bit WIDTH instead of wrapping.
  logic [WIDTH:0]   cnt_ext, step_ext, lim_ext, sum_ext;

  assign mode_s   = mode_e'(mode);
  assign cnt_ext  = {1'b0, count_q};
  assign step_ext = {1'b0, step};
  assign lim_ext  = {1'b0, limit};
  assign sum_ext  = cnt_ext + step_ext;

  ramp_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (load),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;

    if (load) begin
      count_d = (load_value > limit) ? limit : load_value;
    end else if (tick && (step != '0)) begin
      // A zero step never moves the count, so it must never report a wrap
      // either, even when a lowered limit sits below the current count.
      unique case (mode_s)
        MODE_HOLD: ;
        MODE_SAW_UP: begin
          if (sum_ext > lim_ext) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = sum_ext[WIDTH-1:0];
          end
        end
        MODE_SAW_DOWN: begin
          if (cnt_ext < step_ext) begin
            count_d = limit;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - step;
          end
        end
        MODE_TRIANGLE: begin
          if (dir_q == DIR_UP) begin
            if (sum_ext >= lim_ext) begin
              count_d = limit;
              dir_d   = DIR_DOWN;
              wrap_d  = 1'b1;
            end else begin
              count_d = sum_ext[WIDTH-1:0];
            end
          end else begin
            if (cnt_ext <= step_ext) begin
              count_d = '0;
              dir_d   = DIR_UP;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q - step;
            end
          end
        end
        default: ;
      endcase
    end

    // Outside TRIANGLE the direction is parked so a later TRIANGLE selection
    // always starts ascending.
    if (mode_s != MODE_TRIANGLE) begin
      dir_d = DIR_UP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign wrap  = wrap_q;

endmodule : dac_ramp_gen

// File: tb/tb_dac_ramp_gen.sv
// -----------------------------------------------------------------------------
// tb_dac_ramp_gen
// Directed self-checking bench for dac_ramp_gen (WIDTH=8, PRESCALE_W=16).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_dac_ramp_gen;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned PRESCALE_W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enable;
  logic [1:0]            mode;
  logic [WIDTH-1:0]      step;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic                  load;
  logic [WIDTH-1:0]      load_value;
  logic [WIDTH-1:0]      count;
  logic                  dir;
  logic                  wrap;

  int checks   = 0;
  int failures = 0;

  dac_ramp_gen #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .step       (step),
    .limit      (limit),
    .prescale   (prescale),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .dir        (dir),
    .wrap       (wrap)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic chk_out(input string tag, input int c, input int d, input int w);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".dir"},   int'(dir),   d);
    chk({tag, ".wrap"},  int'(wrap),  w);
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int tri_c [9] = '{3, 6, 9, 10, 7, 4, 1, 0, 3};
  int tri_d [9] = '{0, 0, 0, 1,  1, 1, 1, 0, 0};
  int tri_w [9] = '{0, 0, 0, 1,  0, 0, 0, 1, 0};

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    mode       = 2'd0;
    step       = '0;
    limit      = '0;
    prescale   = '0;
    load       = 1'b0;
    load_value = '0;

    // Reset state
    edges(2);
    chk_out("reset", 0, 0, 0);

    // 1: SAW_UP step 1 limit 255 prescale 0 -> 256-clock period
    rst = 1'b0; enable = 1'b1; mode = 2'd1; step = 8'd1; limit = 8'd255;
    for (int k = 1; k <= 257; k++) begin
      edges(1);
      chk($sformatf("saw1.count[%0d]", k), int'(count), k % 256);
      chk($sformatf("saw1.wrap[%0d]", k),  int'(wrap),  (k == 256) ? 1 : 0);
    end

    // 2: SAW_UP step 100 limit 250 prescale 2 -> moves every 3rd clock
    rst = 1'b1; step = 8'd100; limit = 8'd250; prescale = 16'd2;
    edges(1);
    rst = 1'b0;
    edges(2);  chk_out("saw2.e2",  0,   0, 0);
    edges(1);  chk_out("saw2.e3",  100, 0, 0);
    edges(2);  chk_out("saw2.e5",  100, 0, 0);
    edges(1);  chk_out("saw2.e6",  200, 0, 0);
    edges(3);  chk_out("saw2.e9",  0,   0, 1);
    edges(1);  chk_out("saw2.e10", 0,   0, 0);
    edges(2);  chk_out("saw2.e12", 100, 0, 0);

    // 3: TRIANGLE step 3 limit 10
    rst = 1'b1; mode = 2'd3; step = 8'd3; limit = 8'd10; prescale = 16'd0;
    edges(1);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      edges(1);
      chk_out($sformatf("tri[%0d]", k), tri_c[k], tri_d[k], tri_w[k]);
    end

    // 4: SAW_DOWN step 4 limit 9, preload 200 clamps to 9
    mode = 2'd2; step = 8'd4; limit = 8'd9; load = 1'b1; load_value = 8'd200;
    edges(1);  chk_out("down.load", 9, 0, 0);
    load = 1'b0;
    edges(1);  chk_out("down.t1", 5, 0, 0);
    edges(1);  chk_out("down.t2", 1, 0, 0);
    edges(1);  chk_out("down.t3", 9, 0, 1);
    edges(1);  chk_out("down.t4", 5, 0, 0);

    // 5: reset mid-ramp with simultaneous load, then disabled hold
    mode = 2'd1; step = 8'd1; limit = 8'd255; load = 1'b1; load_value = 8'd120;
    edges(1);  chk_out("mid.load", 120, 0, 0);
    rst = 1'b1; load_value = 8'd77; prescale = 16'd2;
    edges(1);  chk_out("mid.rst", 0, 0, 0);
    rst = 1'b0; load = 1'b0; enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      edges(1);
      chk($sformatf("mid.dis[%0d]", k), int'(count), 0);
    end
    enable = 1'b1;
    edges(2);  chk_out("mid.en2", 0, 0, 0);
    edges(1);  chk_out("mid.en3", 1, 0, 0);

    // 6: limit lowered below the count, then step 0, then limit 0
    prescale = 16'd0; load = 1'b1; load_value = 8'd200;
    edges(1);  chk_out("low.load", 200, 0, 0);
    load = 1'b0; limit = 8'd50; step = 8'd0;
    edges(1);  chk_out("low.step0", 200, 0, 0);
    step = 8'd1;
    edges(1);  chk_out("low.over", 0, 0, 1);
    step = 8'd0;
    for (int k = 0; k < 5; k++) begin
      edges(1);
      chk_out($sformatf("low.hold[%0d]", k), 0, 0, 0);
    end
    limit = 8'd0; step = 8'd5;
    edges(1);  chk_out("lim0.up1", 0, 0, 1);
    edges(1);  chk_out("lim0.up2", 0, 0, 1);
    mode = 2'd2;
    edges(1);  chk_out("lim0.down", 0, 0, 1);
    mode = 2'd3;
    edges(1);  chk_out("lim0.tri", 0, 1, 1);
    mode = 2'd0;
    edges(1);  chk_out("lim0.hold", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dac_ramp_gen

// File: doc/dac_ramp_gen.md
Name: dac_ramp_gen

Overview:
Parametrised successor to the free-running 4-bit DAC counter in the adjustable-PSU digital path. It generates an R2R DAC code with programmable width, step, upper limit, tick prescaler and waveform mode: hold, sawtooth up, sawtooth down or triangle. It also supports synchronous preload. It sits between the clock and the R2R DAC pins. Control inputs come from the configuration/IO logic.

Parameters:
WIDTH, 8, DAC code width in bits (minimum 2)
PRESCALE_W, 16, prescaler counter width in bits

Ports:
clk  input  1  system clock (10 MHz nominal)
rst  input  1  synchronous active-high reset
enable  input  1  prescaler and stepping enable; low freezes the prescaler and the count
mode  input  2  0 HOLD, 1 SAW_UP, 2 SAW_DOWN, 3 TRIANGLE
step  input  WIDTH  amount added or subtracted per tick
limit  input  WIDTH  upper bound of the count (inclusive)
prescale  input  PRESCALE_W  tick every prescale+1 enabled cycles
load  input  1  synchronous preload strobe
load_value  input  WIDTH  preload value
count  output  WIDTH  registered DAC code
dir  output  1  registered; 1 = descending (TRIANGLE only)
wrap  output  1  registered single-cycle pulse on wrap or turn-around

Behaviour:
- Reset (rst=1 at a clk edge): count=0, dir=0, wrap=0, prescaler=0. Reset overrides every other input, including mid-ramp.
- Prescaler:
  - Counts enabled cycles from 0 to prescale.
  - tick is asserted in the cycle the prescaler equals prescale; the prescaler then returns to 0.
  - prescale=0 gives a tick every enabled cycle.
  - enable=0 holds the prescaler value and suppresses tick.
- Priority per cycle: rst > load > tick > hold.
- Load:
  - count <= min(load_value, limit); wrap=0; prescaler cleared to 0.
  - dir is unchanged.
  - load is honoured even when enable=0.
- wrap defaults to 0 every cycle unless set by the tick rules below. The output is registered, so the pulse appears in the same cycle as the new count.
- Arithmetic: all compares are done in WIDTH+1 bits; no silent modular overflow.
- step=0: count holds on tick and wrap never fires.
- Tick in HOLD: count holds.
- Tick in SAW_UP:
  - If count+step > limit: count<=0, wrap=1.
  - Otherwise: count<=count+step.
- Tick in SAW_DOWN:
  - If count < step: count<=limit, wrap=1.
  - Otherwise: count<=count-step.
- Tick in TRIANGLE, dir=0:
  - If count+step >= limit: count<=limit, dir<=1, wrap=1.
  - Otherwise: count<=count+step.
- Tick in TRIANGLE, dir=1:
  - If count <= step: count<=0, dir<=0, wrap=1.
  - Otherwise: count<=count-step.
- dir is forced to 0 in any cycle where mode != TRIANGLE, so TRIANGLE always starts ascending.
- limit lowered below the current count: no immediate clamp.
  - The next tick in SAW_UP or ascending TRIANGLE takes the overflow branch (SAW_UP gives 0; TRIANGLE gives limit with dir=1).
  - SAW_DOWN and descending TRIANGLE step down normally.
- limit=0: every non-HOLD tick with step>0 yields count=0 and wrap=1.
- Mode or step changes take effect on the next tick; the prescaler phase is not disturbed.
- count is fully registered; no combinational path from inputs to outputs.

Decomposition:
- Package dac_ramp_pkg holds:
  - mode encodings MODE_HOLD=2'd0, MODE_SAW_UP=2'd1, MODE_SAW_DOWN=2'd2, MODE_TRIANGLE=2'd3;
  - the dir constants DIR_UP=1'b0, DIR_DOWN=1'b1.
- One sub-module, ramp_prescaler: parametrised by PRESCALE_W; inputs clk, rst, enable, clear, prescale; output tick.
- Step, bound and direction logic stays in dac_ramp_gen.

Test Plan:
1. WIDTH=8, SAW_UP, step=1, limit=255, prescale=0, enable=1 -> count 0,1,…,255,0. wrap is high only in the cycle count returns to 0; period is 256 clocks.
2. SAW_UP, step=100, limit=250, prescale=2 -> count changes every 3rd clock: 0,100,200,0 (wrap on the 0), repeating.
3. TRIANGLE, step=3, limit=10 -> count 0,3,6,9,10 (dir=1, wrap), 7,4,1,0 (dir=0, wrap), 3, …
4. SAW_DOWN, step=4, limit=9, load=1 with load_value=200 -> count=9 the cycle after load. Ticks give 5,1,9 (wrap), 5, …
5. Mid-ramp at count=120, assert rst for 1 cycle with load=1 simultaneously -> count=0, dir=0, wrap=0, prescaler restarted. Then enable=0 for 10 cycles -> count stays 0.
6. SAW_UP at count=200, change limit to 50 -> the next tick gives count=0 with wrap=1. Then with step=0, count holds at 0 indefinitely and wrap stays low.
